// File: rtl/wisc_mem_pkg.sv
// Shared types for the fixed-latency data memory responder.
// Holds the FSM state encoding and the in-flight response record.
package wisc_mem_pkg;

    localparam int DEF_LATENCY   = 4;
    localparam int DEF_BURST_LEN = 8;

    // Record fields are wide enough for any practical address/data width.
    localparam int RESP_AW = 32;
    localparam int RESP_DW = 32;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               last;
        logic [RESP_AW-1:0] addr;
        logic [RESP_DW-1:0] data;
    } resp_t;

endpackage

// File: rtl/mem_delay_pipe.sv
// Shift register of response records with synchronous clear.
// Gives read responses their fixed latency.
module mem_delay_pipe
    import wisc_mem_pkg::*;
#(
    parameter int STAGES = DEF_LATENCY - 1
) (
    input  logic  clk,
    input  logic  clr,
    input  resp_t d,
    output resp_t q
);

    resp_t stage [STAGES];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency word memory with single reads, writes and block reads.
// Reads are sampled at issue and travel through a delay pipe.
module memory_responder
    import wisc_mem_pkg::*;
#(
    parameter int AWIDTH     = 16,
    parameter int DWIDTH     = 16,
    parameter int DEPTH_LOG2 = 15,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic              burst,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] data_in,
    output logic              ready,
    output logic              data_valid,
    output logic [DWIDTH-1:0] data_out,
    output logic [AWIDTH-1:0] resp_addr,
    output logic              resp_last
);

    localparam int BW = $clog2(BURST_LEN);
    localparam logic [AWIDTH-1:0] BLOCK_MASK = ~AWIDTH'(2 * BURST_LEN - 1);

    logic [DWIDTH-1:0] mem [2**DEPTH_LOG2];

    state_t            state;
    logic [BW-1:0]     cnt;
    logic [AWIDTH-1:0] base;

    logic              accept;
    logic              rd_en;
    logic              rd_last;
    logic [AWIDTH-1:0] rd_addr;
    resp_t             rec;
    resp_t             pipe_q;

    assign ready  = (state == IDLE) && !rst;
    assign accept = enable && ready;

    // Burst issues own the read port; new requests are blocked meanwhile.
    always_comb begin
        rd_en   = 1'b0;
        rd_last = 1'b0;
        rd_addr = '0;
        if (state == BURST) begin
            rd_en   = 1'b1;
            rd_last = &cnt;
            rd_addr = base | AWIDTH'({cnt, 1'b0});
        end else if (accept && !wr) begin
            rd_en   = 1'b1;
            rd_last = !burst;
            rd_addr = burst ? (addr & BLOCK_MASK)
                            : {addr[AWIDTH-1:1], 1'b0};
        end
    end

    always_comb begin
        rec       = '0;
        rec.valid = rd_en;
        rec.last  = rd_last;
        rec.addr  = RESP_AW'(rd_addr);
        rec.data  = RESP_DW'(mem[rd_addr[DEPTH_LOG2:1]]);
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[addr[DEPTH_LOG2:1]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && !wr && burst) begin
                        state <= BURST;
                        cnt   <= BW'(1);
                        base  <= addr & BLOCK_MASK;
                    end
                end
                BURST: begin
                    cnt <= cnt + BW'(1);
                    if (&cnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_delay_pipe #(
        .STAGES(LATENCY - 1)
    ) u_pipe (
        .clk(clk),
        .clr(rst),
        .d  (rec),
        .q  (pipe_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid <= 1'b0;
            data_out   <= '0;
            resp_addr  <= '0;
            resp_last  <= 1'b0;
        end else begin
            data_valid <= pipe_q.valid;
            data_out   <= pipe_q.valid ? DWIDTH'(pipe_q.data) : '0;
            resp_addr  <= pipe_q.valid ? AWIDTH'(pipe_q.addr) : '0;
            resp_last  <= pipe_q.valid && pipe_q.last;
        end
    end

endmodule
